sec_countdown: RTL
==================

# sec_countdown

Minutes:seconds BCD countdown timer, the stage directly downstream of the 1 Hz clock divider. It samples the divider's 1 Hz square wave in the system clock domain and decrements a preset mm:ss value once per rising edge. It drives BCD digits to the seven-segment scanner and flags expiry. It is a fully synchronous single-clock design; the 1 Hz signal is treated as data, never as a clock.

## Interface
- MAX_MIN, 59: largest loadable minutes value, decimal, 1..99.
- clk  in  1  system clock, 100 MHz; the 1 Hz divider runs on the same clock.
- rst  in  1  synchronous, active-high reset.
- tick_in  in  1  1 Hz square wave from the divider; each rising edge is one second.
- load  in  1  one-cycle pulse; captures min_in/sec_in as the preset.
- start  in  1  one-cycle pulse (debounced button); toggles run/pause.
- min_in  in  8  preset minutes, two BCD digits.
- sec_in  in  8  preset seconds, two BCD digits.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- expire  out  1  one-cycle pulse on the cycle the count reaches 00:00.

## Operation
- Edge detect: tick_q <= tick_in. rise = tick_in & ~tick_q. tick_q resets to 1, so a high tick_in at reset release is not counted.
- Load sanitising, applied per field:
  - Any nibble > 9 becomes 9.
  - Seconds tens > 5 becomes 5.
  - Minutes > MAX_MIN becomes MAX_MIN.
  - The sanitised value goes into both the preset register and the count.
- FSM states: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
  - IDLE: load → capture, stay IDLE. start with nonzero count → RUN. start with count 00:00 → ignored.
  - RUN: start → PAUSE. Otherwise, on rise, decrement. The decrement from 00:01 to 00:00 pulses expire and moves to DONE. load is ignored.
  - PAUSE: start → RUN. load → capture and go to IDLE. Ticks are ignored.
  - DONE: load → capture and go to IDLE. start → IDLE, with the count reloaded from the preset.
- Priorities:
  - load and start in the same cycle: load wins.
  - start and rise in the same cycle in RUN: the state goes to PAUSE and that tick is dropped.
  - On the PAUSE→RUN cycle, a coincident rise is not counted.
- Decrement, BCD borrow chain:
  - Seconds units 0 → 9, borrowing from seconds tens.
  - Seconds tens 0 → 5, borrowing from minutes.
  - Minutes decrement is BCD: x0 → (x-1)9.
  - Decrement is never applied at 00:00.
- Reset values: min_bcd = 0x00, sec_bcd = 0x00, preset = 0x0000, running = 0, done = 0, expire = 0, tick_q = 1.

## Timing
- All outputs are registered.
- A count update happens on the clk edge where tick_in = 1 and tick_q = 0. The new digits are visible the cycle after that edge.
- Latency from tick_in first sampled high to updated outputs: 1 clk.
- Tick to tick spacing is 100,000,000 clk. The block needs only a 1-cycle rise, so it tolerates any tick_in duty cycle.
- expire is asserted in the same cycle that min_bcd/sec_bcd first read 0x00/0x00 and done first reads 1. It is exactly 1 clk wide.
- running and done change on the same edge as the state transition that causes them.
- rst mid-count: on the next clk edge all outputs take their reset values and the preset is cleared.

## Configuration
- TIMER_AUTORELOAD_EN defined:
  - On the 00:01 → 00:00 step in RUN, the count reloads from the preset on the same edge instead of showing 00:00.
  - expire pulses and the FSM stays in RUN; done is never asserted.
  - A preset of 00:00 still cannot start.
- TIMER_AUTORELOAD_EN undefined: behaviour is as described in Operation, and DONE is entered on expiry.

## Test plan
- Reset, then load min_in = 0x01, sec_in = 0x05, then start, then 5 rises → 01:00. One more rise → 00:59, exercising the minutes borrow and seconds tens 0 → 5.
- Load 00:02, start, 2 rises → 00:00, expire is high for exactly 1 clk, done = 1, running = 0. A 3rd rise leaves the count at 00:00.
- Load sec_in = 0x7B, min_in = 0xA0 with MAX_MIN = 59 → count reads 59:59.
- In RUN, assert start in the same cycle as a rise → PAUSE with the count unchanged. 3 rises in PAUSE → no change. start → RUN, and the next rise decrements by 1.
- In IDLE at 00:00, pulse start → stays IDLE. Assert load and start together with 0x00/0x10 → captured 00:10, state IDLE. Hold tick_in high through rst → no decrement after reset.
- With TIMER_AUTORELOAD_EN: load 00:02, start, 2 rises → count reads 00:02, expire pulses, running stays 1, done stays 0.

Source files
------------

// File: rtl/sec_countdown.sv
// mm:ss BCD countdown driven by a 1 Hz data strobe sampled in the clk domain.
// Optional build macro TIMER_AUTORELOAD_EN: reload from preset on expiry and keep running.
module sec_countdown #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       load,
  input  logic       start,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       expire
);

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t     r_state;
  logic       r_tick_q;
  logic [7:0] r_min, r_sec, r_pre_min, r_pre_sec;
  logic       r_running, r_done, r_expire;

  logic       w_rise, w_zero, w_last, w_min_over;
  logic [7:0] w_min_nib, w_sec_nib, w_min_clamp, w_sec_clamp;
  logic [7:0] w_dec_min, w_dec_sec;

  // Clamp every BCD nibble to 9 before the field-level limits are applied
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nib
      assign w_min_nib[gi*4 +: 4] = (min_in[gi*4 +: 4] > 4'd9) ? 4'd9 : min_in[gi*4 +: 4];
      assign w_sec_nib[gi*4 +: 4] = (sec_in[gi*4 +: 4] > 4'd9) ? 4'd9 : sec_in[gi*4 +: 4];
    end
  endgenerate

  assign w_sec_clamp = {((w_sec_nib[7:4] > 4'd5) ? 4'd5 : w_sec_nib[7:4]), w_sec_nib[3:0]};
  assign w_min_over  = (w_min_nib[7:4] > MAX_T) ||
                       ((w_min_nib[7:4] == MAX_T) && (w_min_nib[3:0] > MAX_U));
  assign w_min_clamp = w_min_over ? {MAX_T, MAX_U} : w_min_nib;

  assign w_rise = tick_in & ~r_tick_q;
  assign w_zero = (r_min == 8'h00) && (r_sec == 8'h00);
  assign w_last = (r_min == 8'h00) && (r_sec == 8'h01);

  always_comb begin
    w_dec_min = r_min;
    w_dec_sec = r_sec;
    if (r_sec[3:0] != 4'd0) begin
      w_dec_sec[3:0] = r_sec[3:0] - 4'd1;
    end else begin
      w_dec_sec[3:0] = 4'd9;
      if (r_sec[7:4] != 4'd0) begin
        w_dec_sec[7:4] = r_sec[7:4] - 4'd1;
      end else begin
        w_dec_sec[7:4] = 4'd5;
        if (r_min[3:0] != 4'd0) begin
          w_dec_min[3:0] = r_min[3:0] - 4'd1;
        end else begin
          w_dec_min[3:0] = 4'd9;
          w_dec_min[7:4] = r_min[7:4] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tick_q  <= 1'b1;
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_pre_min <= 8'h00;
      r_pre_sec <= 8'h00;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expire  <= 1'b0;
    end else begin
      r_tick_q <= tick_in;
      r_expire <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_pre_min <= w_min_clamp;
            r_pre_sec <= w_sec_clamp;
            r_min     <= w_min_clamp;
            r_sec     <= w_sec_clamp;
          end else if (start && !w_zero) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          // start beats a coincident tick; load is ignored while counting
          if (start) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end else if (w_rise && !w_zero) begin
            if (w_last) begin
              r_expire <= 1'b1;
`ifdef TIMER_AUTORELOAD_EN
              r_min    <= r_pre_min;
              r_sec    <= r_pre_sec;
`else
              r_min     <= 8'h00;
              r_sec     <= 8'h00;
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
`endif
            end else begin
              r_min <= w_dec_min;
              r_sec <= w_dec_sec;
            end
          end
        end
        S_PAUSE: begin
          if (load) begin
            r_pre_min <= w_min_clamp;
            r_pre_sec <= w_sec_clamp;
            r_min     <= w_min_clamp;
            r_sec     <= w_sec_clamp;
            r_state   <= S_IDLE;
          end else if (start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_DONE: begin
          if (load) begin
            r_pre_min <= w_min_clamp;
            r_pre_sec <= w_sec_clamp;
            r_min     <= w_min_clamp;
            r_sec     <= w_sec_clamp;
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
          end else if (start) begin
            r_min   <= r_pre_min;
            r_sec   <= r_pre_sec;
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign min_bcd = r_min;
  assign sec_bcd = r_sec;
  assign running = r_running;
  assign done    = r_done;
  assign expire  = r_expire;

endmodule
